reg_file: RTL and testbench

- 32 x 32-bit MIPS general register file.
- Receiver side of the writeback path: it consumes the write-back data, destination address and write-enable produced at the end of the pipeline.
- Serves the two operand reads of the ID stage. Internal write-to-read bypass lets ID see a same-cycle writeback without a forwarding mux.
- Also provides a registered debug read port and a writeback event counter for bench and board observation.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/rf_read_port.sv | 30 +++
 rtl/reg_file.sv | 102 ++++++++++
 tb/tb_reg_file.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file constants, types and reset helper.
// Imported by the register file, its read port and the bench model.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd28;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

  localparam logic [DATA_W-1:0] SP_DEFAULT = 32'h0000_07FC;
  localparam logic [DATA_W-1:0] GP_DEFAULT = 32'h0000_1800;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] raddr_t;

  // Writeback bundle arriving from MEM/WB
  typedef struct packed {
    logic   we;
    raddr_t addr;
    word_t  data;
  } wb_t;

  // Reset contents of one register: $sp and $gp preset, rest zero
  function automatic word_t reset_value(
    input raddr_t a,
    input word_t  sp,
    input word_t  gp
  );
    word_t v;
    v = '0;
    unique case (1'b1)
      (a == REG_SP): v = sp;
      (a == REG_GP): v = gp;
      default:       v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational operand read with write bypass.
// Priority: $zero, then same-cycle writeback, then stored value.
module rf_read_port
  import cpu_pkg::*;
(
  input  raddr_t                i_addr,
  input  wb_t                   i_wb,
  input  word_t [NUM_REGS-1:0]  i_regs,
  output word_t                 o_data
);

  logic w_zero;
  logic w_hit;

  assign w_zero = (i_addr == REG_ZERO);
  assign w_hit  = i_wb.we
               && (i_wb.addr == i_addr)
               && !w_zero;

  // Select zero / bypassed writeback / array entry
  always_comb begin
    o_data = '0;
    unique case (1'b1)
      w_zero:  o_data = '0;
      w_hit:   o_data = i_wb.data;
      default: o_data = i_regs[i_addr];
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 MIPS GPR file, two bypassed reads,
// registered debug read and writeback event counter.
module reg_file
  import cpu_pkg::*;
#(
  parameter logic [31:0] SP_INIT = SP_DEFAULT,
  parameter logic [31:0] GP_INIT = GP_DEFAULT,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegAddr,
  input  logic [31:0]      WriteData,
  input  logic [4:0]       ReadAddr1,
  input  logic [4:0]       ReadAddr2,
  output logic [31:0]      ReadData1,
  output logic [31:0]      ReadData2,
  input  logic [4:0]       DbgAddr,
  output logic [31:0]      DbgData,
  output logic [CNT_W-1:0] WbCount
);

  word_t [NUM_REGS-1:0] r_regs;
  word_t                r_dbg;
  logic [CNT_W-1:0]     r_wb_cnt;

  wb_t   w_wb;
  logic  w_commit;
  logic  w_dbg_zero;
  logic  w_dbg_hit;
  word_t w_dbg_next;

  assign w_wb.we   = RegWrite;
  assign w_wb.addr = WriteRegAddr;
  assign w_wb.data = WriteData;

  assign w_commit = RegWrite
                 && (WriteRegAddr != REG_ZERO);

  // Storage array; $zero is never written so it stays 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= reset_value(
          raddr_t'(i), SP_INIT, GP_INIT);
      end
    end else if (w_commit) begin
      r_regs[WriteRegAddr] <= WriteData;
    end
  end

  rf_read_port u_rd1 (
    .i_addr (ReadAddr1),
    .i_wb   (w_wb),
    .i_regs (r_regs),
    .o_data (ReadData1)
  );

  rf_read_port u_rd2 (
    .i_addr (ReadAddr2),
    .i_wb   (w_wb),
    .i_regs (r_regs),
    .o_data (ReadData2)
  );

  assign w_dbg_zero = (DbgAddr == REG_ZERO);
  assign w_dbg_hit  = w_commit
                   && (WriteRegAddr == DbgAddr);

  // Debug value as the register will read after this edge
  always_comb begin
    w_dbg_next = '0;
    unique case (1'b1)
      w_dbg_zero: w_dbg_next = '0;
      w_dbg_hit:  w_dbg_next = WriteData;
      default:    w_dbg_next = r_regs[DbgAddr];
    endcase
  end

  // Registered debug read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg <= '0;
    end else begin
      r_dbg <= w_dbg_next;
    end
  end

  // Committed-write counter, free-running wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_cnt <= '0;
    end else if (w_commit) begin
      r_wb_cnt <= r_wb_cnt + 1'b1;
    end
  end

  assign DbgData = r_dbg;
  assign WbCount = r_wb_cnt;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file.
// Expected values queued at drive time, popped at sample time.
module tb_reg_file;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DbgAddr;
  logic [31:0] DbgData;
  logic [15:0] WbCount;

  reg_file #(
    .SP_INIT (32'h0000_07FC),
    .GP_INIT (32'h0000_1800),
    .CNT_W   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegAddr (WriteRegAddr),
    .WriteData    (WriteData),
    .ReadAddr1    (ReadAddr1),
    .ReadAddr2    (ReadAddr2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .DbgAddr      (DbgAddr),
    .DbgData      (DbgData),
    .WbCount      (WbCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_regs [32];
  logic [15:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_out(input int src);
    case (src)
      0:       return ReadData1;
      1:       return ReadData2;
      2:       return DbgData;
      default: return {16'h0, WbCount};
    endcase
  endfunction

  task automatic push(input string tag, input int src,
                      input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.src = src;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      chk(x.tag, dut_out(x.src), x.exp);
    end
  endtask

  // Golden read: $zero, committed-write bypass, array
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (RegWrite && WriteRegAddr == a) return WriteData;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[28] = GP_DEFAULT;
    m_regs[29] = SP_DEFAULT;
    m_cnt = 16'h0;
  endtask

  // One cycle, entered just after a negedge
  task automatic step(input logic we, input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic [4:0] da, input bit do_chk,
                      input string tag);
    logic [31:0] dbg_exp;
    RegWrite     = we;
    WriteRegAddr = wa;
    WriteData    = wd;
    ReadAddr1    = ra1;
    ReadAddr2    = ra2;
    DbgAddr      = da;
    #1;
    dbg_exp = m_rd(da);
    if (do_chk) begin
      push({tag, "_rd1"}, 0, m_rd(ra1));
      push({tag, "_rd2"}, 1, m_rd(ra2));
      drain();
    end
    @(posedge clk);
    if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
      m_cnt      = m_cnt + 16'd1;
    end
    @(negedge clk);
    if (do_chk) begin
      push({tag, "_dbg"}, 2, dbg_exp);
      push({tag, "_cnt"}, 3, {16'h0, m_cnt});
      drain();
    end
  endtask

  initial begin
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegAddr = '0;
    WriteData = '0;
    ReadAddr1 = '0;
    ReadAddr2 = '0;
    DbgAddr = '0;
    m_reset();

    // Reset state while held
    repeat (2) @(negedge clk);
    ReadAddr1 = 5'd28;
    ReadAddr2 = 5'd29;
    #1;
    push("rst_gp", 0, 32'h0000_1800);
    push("rst_sp", 1, 32'h0000_07FC);
    push("rst_dbg", 2, 32'h0);
    push("rst_cnt", 3, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Sweep all addresses on all three read ports
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i),
           1'b1, $sformatf("sweep%0d", i));
    end

    // Write then read
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd0, 1'b1, "wr5");
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 1'b1, "rd5");

    // Dual bypass, then array holds it
    step(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd6, 1'b1, "byp7");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b1, "arr7");

    // Write to $zero is discarded and not counted
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b1, "z_wr");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 5'd0, 1'b1, "z_after");

    // Debug sees same-edge write
    step(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd3, 5'd9, 1'b1, "dbg9");
    step(1'b1, 5'd29, 32'h0000_0100, 5'd28, 5'd29, 5'd29, 1'b1, "sp");

    // Random mixed traffic
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom),
           $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
           1'b1, $sformatf("rnd%0d", i));
    end

    // Async reset mid-stream
    step(1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd3, 5'd3, 1'b1, "wr3");
    RegWrite  = 1'b0;
    ReadAddr1 = 5'd3;
    ReadAddr2 = 5'd29;
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    push("arst_rd3", 0, 32'h0);
    push("arst_sp", 1, 32'h0000_07FC);
    push("arst_dbg", 2, 32'h0);
    push("arst_cnt", 3, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Wrap: 65534 silent writes, then two checked
    for (int i = 0; i < 65534; i++) begin
      step(1'b1, 5'(1 + (i % 31)), $urandom, 5'd0, 5'd0,
           5'd0, 1'b0, "pre");
    end
    step(1'b1, 5'd12, 32'h0BAD_F00D, 5'd12, 5'd11, 5'd12, 1'b1, "ffff");
    step(1'b1, 5'd13, 32'h1357_9BDF, 5'd13, 5'd12, 5'd13, 1'b1, "wrap");
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd30, 5'd31, 1'b1, "post");

    if (q.size() != 0) begin
      chk("queue_empty", 32'(q.size()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
